// File: rtl/uart_fifo_core.sv
// Full-duplex UART: bit-timed transmitter, 16x-oversampled receiver with
// parity/framing/overrun detection, and a first-word-fall-through RX FIFO.
module uart_fifo_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_overrun
);

  localparam int DIV_RAW  = CLK_HZ / (16 * BAUD);
  localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_CLKS = 16 * DIV;
  localparam int BT_W     = $clog2(BIT_CLKS);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  // ---------------- oversampling tick ----------------
  logic [DIV_W-1:0] div_cnt;
  logic             os_tick;

  assign os_tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       div_cnt <= '0;
    else if (os_tick) div_cnt <= '0;
    else              div_cnt <= div_cnt + DIV_W'(1);
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t            tx_state;
  logic [BT_W-1:0]      tx_timer;
  logic [DATA_BITS-1:0] tx_shift;
  logic [3:0]           tx_bit;
  logic                 tx_par;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_timer == BT_W'(BIT_CLKS - 1));

  // NOTE: every register in a clocked block uses <= so all updates see the
  // pre-edge values; a blocking = here would chain through the case arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      if (tx_state != TX_IDLE)
        tx_timer <= tx_bit_end ? '0 : tx_timer + BT_W'(1);
      case (tx_state)
        TX_IDLE: if (tx_valid && tx_ready) begin
          tx_shift <= tx_data;
          tx_par   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
          tx_timer <= '0;
          tx_bit   <= '0;
          tx       <= 1'b0;
          tx_ready <= 1'b0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_bit_end) begin
          tx       <= tx_shift[0];
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit == 4'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx       <= tx_par;
              tx_state <= TX_PARITY;
            end else begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end
          end else begin
            tx_bit   <= tx_bit + 4'd1;
            tx_shift <= tx_shift >> 1;
            tx       <= tx_shift[1];
          end
        end
        TX_PARITY: if (tx_bit_end) begin
          tx       <= 1'b1;
          tx_state <= TX_STOP;
        end
        TX_STOP: if (tx_bit_end) begin
          tx_ready <= 1'b1;
          tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  rx_state_t            rx_state;
  logic [1:0]           rx_sync;
  logic                 rx_s;
  logic [3:0]           rx_cnt;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic                 par_ok;
  logic                 push_req;
  logic                 mid_bit;

  assign rx_s    = rx_sync[1];
  assign mid_bit = os_tick && (rx_cnt == 4'd15);
  assign par_ok  = (PARITY == 0) ||
                   (rx_par_bit == ((PARITY == 1) ? ~^rx_shift : ^rx_shift));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par_bit    <= 1'b0;
      push_req      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      push_req      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      if (os_tick && rx_state inside {RX_DATA, RX_PARITY, RX_STOP})
        rx_cnt <= (rx_cnt == 4'd15) ? 4'd0 : rx_cnt + 4'd1;
      case (rx_state)
        RX_IDLE: if (os_tick && !rx_s) begin
          rx_cnt   <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (os_tick) begin
          if (rx_cnt == 4'd7) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 4'd1;
          end
        end
        RX_DATA: if (mid_bit) begin
          rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == 4'(DATA_BITS - 1))
            rx_state <= (PARITY != 0) ? RX_PARITY : RX_STOP;
          else
            rx_bit <= rx_bit + 4'd1;
        end
        RX_PARITY: if (mid_bit) begin
          rx_par_bit <= rx_s;
          rx_state   <= RX_STOP;
        end
        RX_STOP: if (mid_bit) begin
          // A low stop bit masks any parity result: report framing only.
          if (!rx_s) begin
            rx_frame_err <= 1'b1;
            rx_state     <= RX_BREAK;
          end else begin
            push_req      <= par_ok;
            rx_parity_err <= !par_ok;
            rx_state      <= RX_IDLE;
          end
        end
        RX_BREAK: if (rx_s) rx_state <= RX_IDLE;
        default:  rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO (first-word fall-through) ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 full, pop, do_push;

  assign full       = (rx_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop        = rx_valid && rx_ready;
  assign do_push    = push_req && (!full || pop);
  assign rx_overrun = push_req && full && !pop;
  assign rx_valid   = (rx_count != '0);
  assign rx_data    = mem[rd_ptr];

  // NOTE: storage has no reset; rx_valid gates every read, so stale
  // contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: an 8N1 loopback instance and an even-parity,
// depth-4 instance driven by bit-banged frames from a directed vector table.
`timescale 1ns/1ps
module tb_uart_fifo_core;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int BIT    = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- loopback instance: 8N1, depth 16 ----------------
  logic       lb_rst_n, lb_tx_valid, lb_tx_ready, lb_tx, lb_rx_valid, lb_rx_ready;
  logic [7:0] lb_tx_data, lb_rx_data;
  logic [4:0] lb_rx_count;
  logic       lb_perr, lb_ferr, lb_ovr;

  uart_fifo_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) u_lb (
    .clk(clk), .rst_n(lb_rst_n),
    .tx_data(lb_tx_data), .tx_valid(lb_tx_valid), .tx_ready(lb_tx_ready), .tx(lb_tx),
    .rx(lb_tx),
    .rx_data(lb_rx_data), .rx_valid(lb_rx_valid), .rx_ready(lb_rx_ready), .rx_count(lb_rx_count),
    .rx_parity_err(lb_perr), .rx_frame_err(lb_ferr), .rx_overrun(lb_ovr)
  );

  // ---------------- receive instance: even parity, depth 4 ----------------
  logic       pr_rst_n, pr_tx_valid, pr_tx_ready, pr_tx, pr_line, pr_rx_valid, pr_rx_ready;
  logic [7:0] pr_tx_data, pr_rx_data;
  logic [2:0] pr_rx_count;
  logic       pr_perr, pr_ferr, pr_ovr;

  uart_fifo_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) u_par (
    .clk(clk), .rst_n(pr_rst_n),
    .tx_data(pr_tx_data), .tx_valid(pr_tx_valid), .tx_ready(pr_tx_ready), .tx(pr_tx),
    .rx(pr_line),
    .rx_data(pr_rx_data), .rx_valid(pr_rx_valid), .rx_ready(pr_rx_ready), .rx_count(pr_rx_count),
    .rx_parity_err(pr_perr), .rx_frame_err(pr_ferr), .rx_overrun(pr_ovr)
  );

  int lb_err_n = 0, pr_perr_n = 0, pr_ferr_n = 0, pr_ovr_n = 0;
  always @(negedge clk) begin
    if (lb_perr || lb_ferr || lb_ovr) lb_err_n++;
    if (pr_perr) pr_perr_n++;
    if (pr_ferr) pr_ferr_n++;
    if (pr_ovr)  pr_ovr_n++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_frame(input logic [7:0] d, input logic p);
    pr_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pr_line = d[i];
      repeat (BIT) @(negedge clk);
    end
    pr_line = p;
    repeat (BIT) @(negedge clk);
    pr_line = 1'b1;
    repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic pr_pop(input logic [7:0] exp);
    check("pr pop data", pr_rx_data, exp);
    pr_rx_ready = 1'b1;
    @(negedge clk);
    pr_rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic lb_pop(input logic [7:0] exp);
    check("lb pop data", lb_rx_data, exp);
    lb_rx_ready = 1'b1;
    @(negedge clk);
    lb_rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_lb_ready(output int unsigned at, output logic ok);
    at = 0;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (lb_tx_ready) begin
        at = cyc;
        ok = 1'b1;
        return;
      end
    end
  endtask

  // ---------------- vector table for the receive instance ----------------
  typedef enum {K_FRAME, K_POP, K_BREAK, K_GLITCH} kind_t;
  typedef struct {
    kind_t      kind;
    logic [7:0] data;     // frame payload, or expected word for K_POP
    logic       par_bit;
    int         exp_count;
    logic [7:0] exp_head;
    int         exp_perr;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  function automatic vec_t mk(kind_t k, logic [7:0] d, logic p, int c, logic [7:0] h,
                              int pe, int fe, int ov);
    vec_t v;
    v.kind = k; v.data = d; v.par_bit = p; v.exp_count = c; v.exp_head = h;
    v.exp_perr = pe; v.exp_ferr = fe; v.exp_ovr = ov;
    return v;
  endfunction

  initial begin
    int unsigned t0, t1, t2, t3;
    logic        ok;
    logic [9:0]  frame_bits;

    vecs[0]  = mk(K_FRAME,  8'h55, 1'b1, 0, 8'h00, 1, 0, 0);  // bad even parity
    vecs[1]  = mk(K_FRAME,  8'h55, 1'b0, 1, 8'h55, 1, 0, 0);
    vecs[2]  = mk(K_POP,    8'h55, 1'b0, 0, 8'h00, 1, 0, 0);
    vecs[3]  = mk(K_BREAK,  8'h00, 1'b0, 0, 8'h00, 1, 1, 0);
    vecs[4]  = mk(K_FRAME,  8'h12, 1'b0, 1, 8'h12, 1, 1, 0);
    vecs[5]  = mk(K_POP,    8'h12, 1'b0, 0, 8'h00, 1, 1, 0);
    vecs[6]  = mk(K_FRAME,  8'h01, 1'b1, 1, 8'h01, 1, 1, 0);
    vecs[7]  = mk(K_FRAME,  8'h02, 1'b1, 2, 8'h01, 1, 1, 0);
    vecs[8]  = mk(K_FRAME,  8'h03, 1'b0, 3, 8'h01, 1, 1, 0);
    vecs[9]  = mk(K_FRAME,  8'h04, 1'b1, 4, 8'h01, 1, 1, 0);
    vecs[10] = mk(K_FRAME,  8'h05, 1'b0, 4, 8'h01, 1, 1, 1);  // dropped, FIFO full
    vecs[11] = mk(K_GLITCH, 8'h00, 1'b0, 4, 8'h01, 1, 1, 1);

    lb_rst_n = 1'b0; lb_tx_data = '0; lb_tx_valid = 1'b0; lb_rx_ready = 1'b0;
    pr_rst_n = 1'b0; pr_tx_data = '0; pr_tx_valid = 1'b0; pr_rx_ready = 1'b0; pr_line = 1'b1;

    repeat (3) @(negedge clk);
    check("rst tx",       lb_tx, 1);
    check("rst tx_ready", lb_tx_ready, 1);
    check("rst rx_valid", lb_rx_valid, 0);
    check("rst rx_count", lb_rx_count, 0);
    check("rst errors",   {lb_perr, lb_ferr, lb_ovr}, 0);
    lb_rst_n = 1'b1;
    pr_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post-rst pr count", pr_rx_count, 0);
    check("post-rst pr valid", pr_rx_valid, 0);

    // ---- loopback: 0xA5 then 0x3C back-to-back ----
    lb_tx_data  = 8'hA5;
    lb_tx_valid = 1'b1;
    @(negedge clk);
    check("lb start bit", lb_tx, 0);
    check("lb ready drop", lb_tx_ready, 0);
    t0 = cyc;
    lb_tx_data = 8'h3C;
    frame_bits = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      while (cyc < t0 + 80 + BIT * k) @(negedge clk);
      check($sformatf("lb A5 bit%0d", k), lb_tx, frame_bits[k]);
    end
    wait_lb_ready(t1, ok);
    check("lb frame1 done", ok, 1);
    check("lb frame1 len", t1 - t0, 1600);
    @(negedge clk);
    check("lb frame2 start", lb_tx, 0);
    check("lb gap", cyc - t1, 1);
    t2 = cyc;
    lb_tx_valid = 1'b0;
    wait_lb_ready(t3, ok);
    check("lb frame2 done", ok, 1);
    check("lb frame2 len", t3 - t2, 1600);
    repeat (20) @(negedge clk);
    check("lb count 2", lb_rx_count, 2);
    lb_pop(8'hA5);
    lb_pop(8'h3C);
    check("lb count 0", lb_rx_count, 0);

    // ---- receive instance, table driven ----
    for (int i = 0; i < NV; i++) begin
      case (vecs[i].kind)
        K_FRAME: drive_frame(vecs[i].data, vecs[i].par_bit);
        K_POP:   pr_pop(vecs[i].data);
        K_BREAK: begin
          pr_line = 1'b0;
          repeat (20 * BIT) @(negedge clk);
          pr_line = 1'b1;
          repeat (2 * BIT) @(negedge clk);
        end
        K_GLITCH: begin
          pr_line = 1'b0;
          repeat (50) @(negedge clk);
          pr_line = 1'b1;
          repeat (3 * BIT) @(negedge clk);
        end
        default: ;
      endcase
      check($sformatf("v%0d count", i), pr_rx_count, vecs[i].exp_count);
      if (vecs[i].exp_count != 0)
        check($sformatf("v%0d head", i), pr_rx_data, vecs[i].exp_head);
      check($sformatf("v%0d parity_err", i), pr_perr_n, vecs[i].exp_perr);
      check($sformatf("v%0d frame_err", i), pr_ferr_n, vecs[i].exp_ferr);
      check($sformatf("v%0d overrun", i), pr_ovr_n, vecs[i].exp_ovr);
    end

    // ---- full FIFO: pop exactly in the push cycle of 0x06 ----
    fork
      drive_frame(8'h06, 1'b0);
      begin : watch_push
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
          @(posedge clk);
          #1;
          if (u_par.push_req) begin
            hit = 1'b1;
            check("simul head", pr_rx_data, 8'h01);
            pr_rx_ready = 1'b1;
            @(posedge clk);
            #1;
            pr_rx_ready = 1'b0;
          end
        end
        check("simul push seen", hit, 1);
      end
    join
    @(negedge clk);
    check("simul count", pr_rx_count, 4);
    check("simul overrun", pr_ovr_n, 1);
    pr_pop(8'h02);
    check("drain count 3", pr_rx_count, 3);
    pr_pop(8'h03);
    pr_pop(8'h04);
    pr_pop(8'h06);
    check("drain count 0", pr_rx_count, 0);
    check("drain valid", pr_rx_valid, 0);

    // ---- reset during transmission of 0xFF ----
    lb_tx_data  = 8'hFF;
    lb_tx_valid = 1'b1;
    @(negedge clk);
    lb_tx_valid = 1'b0;
    check("rst-test start", lb_tx, 0);
    repeat (60) @(negedge clk);
    #2 lb_rst_n = 1'b0;
    #1;
    check("async rst tx", lb_tx, 1);
    check("async rst ready", lb_tx_ready, 1);
    repeat (3) @(negedge clk);
    lb_rst_n = 1'b1;
    repeat (BIT) @(negedge clk);
    lb_tx_data  = 8'h81;
    lb_tx_valid = 1'b1;
    @(negedge clk);
    lb_tx_valid = 1'b0;
    t0 = cyc;
    wait_lb_ready(t1, ok);
    check("post-rst frame done", ok, 1);
    check("post-rst frame len", t1 - t0, 1600);
    repeat (20) @(negedge clk);
    check("post-rst count", lb_rx_count, 1);
    check("post-rst data", lb_rx_data, 8'h81);
    check("lb no errors", lb_err_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_core.md
# uart_fifo_core

Parametrised full-duplex UART core: one transmitter, one 16x-oversampled receiver and a first-word-fall-through RX FIFO. It replaces the fixed 8N1 transmit/receive pair with one block. Data width, parity mode, baud rate and FIFO depth are all configurable, and it adds parity/framing/overrun detection and valid/ready handshakes. It sits between the WiFi module serial pins and the command state machine, running on the 50 MHz system clock.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- BAUD, 9600, line rate; DIV = CLK_HZ/(16*BAUD), truncated, forced to a minimum of 1
- DATA_BITS, 8, payload bits per frame, legal range 5..9
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- FIFO_DEPTH, 16, RX FIFO entries, power of two, minimum 2
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  send request
- tx_ready  out  1  transmitter idle; transfer occurs when tx_valid && tx_ready
- tx  out  1  serial output, idles high
- rx  in  1  serial input, asynchronous
- rx_data  out  DATA_BITS  FIFO head word
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  pop; pop occurs when rx_valid && rx_ready
- rx_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- rx_parity_err  out  1  one-cycle pulse, parity mismatch
- rx_frame_err  out  1  one-cycle pulse, stop bit sampled low
- rx_overrun  out  1  one-cycle pulse, byte dropped because FIFO was full

## Operation
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_count=0, all error pulses 0. Both FSMs reset to IDLE and the FIFO pointers to 0.
- Tick generator: a free-running counter 0..DIV-1 produces a one-cycle os_tick at DIV-1. The RX path runs on os_tick.
- TX FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
  - On handshake, tx_data is latched and the TX bit timer is cleared.
  - The TX bit timer is private to TX and independent of os_tick. Each bit lasts exactly 16*DIV clocks.
  - Data bits are sent LSB first.
  - Parity bit value: even mode = XOR of the data bits; odd mode = its inverse.
  - One stop bit.
- RX input: rx passes through a 2-flop synchroniser, with reset value 1.
- RX FSM states: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE | BREAK.
  - IDLE: a synchronised low on an os_tick enters START with the sample counter at 0.
  - START: the line is sampled at count 7. If high, it is a false start and the FSM returns to IDLE with no error.
  - DATA, PARITY and STOP: each is sampled every 16 os_ticks after the previous sample. DATA bits are shifted in LSB first.
  - STOP sample high and parity OK: the word is pushed to the FIFO.
  - STOP sample high and parity bad: the word is discarded and rx_parity_err pulses.
  - STOP sample low: the word is discarded, rx_frame_err pulses, and the FSM enters BREAK.
  - BREAK: waits for the synchronised line to go high, then enters IDLE.
  - Parity and framing errors together: only rx_frame_err pulses.
- FIFO behaviour:
  - Push when full without a simultaneous pop: the word is dropped, rx_overrun pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle: both happen and rx_count is unchanged. This also applies when full, with no overrun.
  - Pop while empty is ignored.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- Reset asserted mid-frame: the frame is abandoned immediately and tx returns to 1 asynchronously. No error is flagged after release.

## Timing
- tx falls on the clock edge following the handshake cycle. tx_ready drops in the same edge.
- TX frame length: (2 + DATA_BITS + (PARITY!=0)) * 16 * DIV clocks.
- tx_ready rises on the edge that ends the stop bit. A new handshake in that cycle starts the next frame with no idle gap.
- RX push occurs 1 clock after the mid-stop-bit os_tick sample. rx_valid and rx_count update on the following edge.
- Error pulses are coincident with the push cycle.
- rx_data is valid combinationally from FIFO storage whenever rx_valid=1 (FWFT behaviour).
- Receiver tolerance: ±3% baud mismatch over a 12-bit frame.

## Test plan
Bench parameters: CLK_HZ=1600000, BAUD=10000 (DIV=10, 160 clocks per bit).
- Loopback (tx tied to rx), 8N1: send 0xA5 then 0x3C back-to-back.
  - Required: a 1600-clock frame each, with no idle gap between them.
  - Required: rx_data 0xA5 then 0x3C, and rx_count reaches 2.
- PARITY=2: drive a frame 0x55 with parity bit 1.
  - Required: rx_parity_err pulses once and rx_count stays 0.
  - Repeat with parity bit 0: 0x55 is received with no error.
- Hold rx low for 20 bit times.
  - Required: one rx_frame_err pulse, no push, no further frames until the line returns high.
  - Then receive 0x12 correctly.
- FIFO_DEPTH=4, rx_ready=0: receive 0x01..0x05.
  - Required: rx_count=4 and rx_overrun pulses on 0x05.
  - Required: pops return 0x01..0x04.
  - With the FIFO full, pop in the exact push cycle of 0x06: no overrun and count stays 4.
- Glitch: pull rx low for 50 clocks.
  - Required: false start, no error, FSM back in IDLE.
- Assert rst_n mid-transmission of 0xFF.
  - Required: tx=1 and tx_ready=1 asynchronously.
  - Required: the next send after reset release is transmitted intact.
